// File: rtl/sm_run_ctrl_pkg.sv
// rtl/sm_run_ctrl_pkg.sv - opcode and state encodings shared by sm_run_ctrl and its bench
package sm_run_ctrl_pkg;

  localparam logic [2:0] SM_RC_OP_HALT    = 3'b000;
  localparam logic [2:0] SM_RC_OP_RUN     = 3'b001;
  localparam logic [2:0] SM_RC_OP_STEP    = 3'b010;
  localparam logic [2:0] SM_RC_OP_READREG = 3'b011;
  localparam logic [2:0] SM_RC_OP_SETBP   = 3'b100;
  localparam logic [2:0] SM_RC_OP_CLRBP   = 3'b101;

  typedef enum logic [2:0] {
    SM_RC_ST_HALTED   = 3'd0,
    SM_RC_ST_RUNNING  = 3'd1,
    SM_RC_ST_STEPPING = 3'd2,
    SM_RC_ST_RDADDR   = 3'd3,
    SM_RC_ST_RESP     = 3'd4
  } sm_rc_state_t;

endpackage

// File: rtl/sm_run_ctrl.sv
// rtl/sm_run_ctrl.sv - run/halt/step/breakpoint controller and register reader for the schoolRISCV core
//
// Drives the core clock enable and reads the register file through its debug port.
// Optional breakpoint logic: define SM_RUN_CTRL_BREAKPOINT_EN.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/ready/op/arg command channel (HALT, RUN, STEP, READREG, SETBP, CLRBP)
//   rsp_valid/ready/data  register read response channel
//   cpu_en                clock enable to the core
//   pc                    current core PC
//   regAddr / regData     core register-file debug read port
//   halted                high in HALTED
//   bp_hit                sticky breakpoint-stop flag
module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter bit RUN_ON_RESET = 1'b1,
  parameter int STEP_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        cpu_en,
  input  logic [31:0] pc,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        halted,
  output logic        bp_hit
);

  localparam sm_rc_state_t ST_RESET = RUN_ON_RESET ? SM_RC_ST_RUNNING : SM_RC_ST_HALTED;

  sm_rc_state_t      r_state, w_state_nxt;
  logic              r_ret_run, w_ret_nxt;
  logic [STEP_W-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]        r_idx, w_idx_nxt;
  logic [31:0]       r_rsp_data, w_rsp_nxt;

  logic w_accept;
  logic w_hit;
  logic w_reading;
  logic w_run_ctx;

  assign cmd_ready = (r_state == SM_RC_ST_HALTED) || (r_state == SM_RC_ST_RUNNING);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_reading = (r_state == SM_RC_ST_RDADDR) || (r_state == SM_RC_ST_RESP);
  // Cycles in which the core would be executing were it not for a breakpoint.
  assign w_run_ctx = (r_state == SM_RC_ST_RUNNING) || (w_reading && r_ret_run);

`ifdef SM_RUN_CTRL_BREAKPOINT_EN
  logic [31:0] r_bp_addr;
  logic        r_bp_valid;
  logic        r_bp_arm;
  logic        r_bp_hit;

  assign w_hit  = r_bp_valid && r_bp_arm && (pc == r_bp_addr);
  assign bp_hit = r_bp_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bp_addr  <= '0;
      r_bp_valid <= 1'b0;
      r_bp_arm   <= 1'b0;
      r_bp_hit   <= 1'b0;
    end else begin
      if (w_accept && cmd_op == SM_RC_OP_SETBP) begin
        r_bp_addr  <= cmd_arg;
        r_bp_valid <= 1'b1;
      end else if (w_accept && cmd_op == SM_RC_OP_CLRBP) begin
        r_bp_valid <= 1'b0;
      end
      // Disarm for the first RUNNING cycle so RUN can leave a breakpoint address.
      if (r_state == SM_RC_ST_HALTED && w_accept && cmd_op == SM_RC_OP_RUN)
        r_bp_arm <= 1'b0;
      else if (w_run_ctx)
        r_bp_arm <= 1'b1;
      if (w_run_ctx && w_hit)
        r_bp_hit <= 1'b1;
      else if (w_accept && (cmd_op == SM_RC_OP_RUN || cmd_op == SM_RC_OP_STEP))
        r_bp_hit <= 1'b0;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{pc, cmd_arg};
  assign w_hit    = 1'b0;
  assign bp_hit   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret_run;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rsp_nxt   = r_rsp_data;
    case (r_state)
      SM_RC_ST_HALTED: begin
        if (w_accept) begin
          case (cmd_op)
            SM_RC_OP_RUN: w_state_nxt = SM_RC_ST_RUNNING;
            SM_RC_OP_STEP: begin
              if (cmd_arg[STEP_W-1:0] != '0) begin
                w_state_nxt = SM_RC_ST_STEPPING;
                w_cnt_nxt   = cmd_arg[STEP_W-1:0];
              end
            end
            SM_RC_OP_READREG: begin
              w_state_nxt = SM_RC_ST_RDADDR;
              w_ret_nxt   = 1'b0;
              w_idx_nxt   = cmd_arg[4:0];
            end
            default: ;
          endcase
        end
      end
      SM_RC_ST_RUNNING: begin
        if (w_accept && cmd_op == SM_RC_OP_READREG) begin
          w_state_nxt = SM_RC_ST_RDADDR;
          w_ret_nxt   = !w_hit;
          w_idx_nxt   = cmd_arg[4:0];
        end else if (w_hit) begin
          w_state_nxt = SM_RC_ST_HALTED;
        end else if (w_accept && (cmd_op == SM_RC_OP_HALT || cmd_op == SM_RC_OP_STEP)) begin
          w_state_nxt = SM_RC_ST_HALTED;
        end
      end
      SM_RC_ST_STEPPING: begin
        w_cnt_nxt = r_cnt - STEP_W'(1);
        if (r_cnt == STEP_W'(1))
          w_state_nxt = SM_RC_ST_HALTED;
      end
      SM_RC_ST_RDADDR: begin
        w_rsp_nxt   = regData;
        w_state_nxt = SM_RC_ST_RESP;
        if (r_ret_run && w_hit)
          w_ret_nxt = 1'b0;
      end
      SM_RC_ST_RESP: begin
        if (r_ret_run && w_hit)
          w_ret_nxt = 1'b0;
        if (rsp_ready)
          w_state_nxt = w_ret_nxt ? SM_RC_ST_RUNNING : SM_RC_ST_HALTED;
      end
      default: w_state_nxt = SM_RC_ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RESET;
      r_ret_run  <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ret_run  <= w_ret_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_rsp_data <= w_rsp_nxt;
    end
  end

  // A hit blocks the enable combinationally so the instruction at bp_addr never executes.
  assign cpu_en    = (w_run_ctx && !w_hit) || (r_state == SM_RC_ST_STEPPING);
  assign halted    = (r_state == SM_RC_ST_HALTED);
  assign rsp_valid = (r_state == SM_RC_ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign regAddr   = w_reading ? r_idx : 5'd0;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// tb/tb_sm_run_ctrl.sv - randomized self-checking bench for sm_run_ctrl with a toy core model
module tb_sm_run_ctrl;
  import sm_run_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'b000;
  logic [31:0] cmd_arg = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        cpu_en;
  logic [31:0] pc;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        halted;
  logic        bp_hit;

  logic [31:0] regs [32];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_pc = '0;

  always #5 clk = ~clk;

  sm_run_ctrl #(.RUN_ON_RESET(1'b0), .STEP_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cpu_en(cpu_en), .pc(pc), .regAddr(regAddr), .regData(regData),
    .halted(halted), .bp_hit(bp_hit)
  );

  // Toy core: one instruction per enabled cycle, register file read combinationally.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else if (cpu_en) pc <= pc + 32'd4;
  assign regData = regs[regAddr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with that cycle number.
  task automatic send(input logic [2:0] op, input logic [31:0] arg, output int unsigned acc);
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_op = op;
    cmd_arg = arg;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic do_step(input int n);
    int unsigned a;
    int cnt = 0;
    logic first;
    send(SM_RC_OP_STEP, n, a);
    first = cpu_en;
    for (int i = 0; i < n + 3; i++) begin
      if (cpu_en) cnt++;
      @(negedge clk);
    end
    check("step_first_en", {31'd0, first}, {31'd0, n != 0});
    check("step_en_cycles", cnt, n);
    exp_pc = exp_pc + 32'(4 * n);
    check("step_pc", pc, exp_pc);
    check("step_halted", {31'd0, halted}, 32'd1);
  endtask

  task automatic do_read(input int idx, input int hold, input logic running);
    int unsigned a;
    rsp_ready = (hold == 0);
    send(SM_RC_OP_READREG, idx, a);
    check("rd_addr", {27'd0, regAddr}, idx);
    check("rd_valid_early", {31'd0, rsp_valid}, 32'd0);
    check("rd_cpu_en", {31'd0, cpu_en}, {31'd0, running});
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      check("rd_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("rd_hold_data", rsp_data, regs[idx]);
      check("rd_hold_cpu_en", {31'd0, cpu_en}, {31'd0, running});
      @(negedge clk);
    end
    check("rd_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_data", rsp_data, regs[idx]);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rd_done_valid", {31'd0, rsp_valid}, 32'd0);
    check("rd_done_ready", {31'd0, cmd_ready}, 32'd1);
    check("rd_done_addr", {27'd0, regAddr}, 32'd0);
  endtask

  task automatic do_run(input int k, input logic with_read);
    int unsigned a, h;
    send(SM_RC_OP_RUN, 32'd0, a);
    check("run_en", {31'd0, cpu_en}, 32'd1);
    repeat (k) @(negedge clk);
    if (with_read) do_read($urandom_range(0, 31), $urandom_range(0, 4), 1'b1);
    send(SM_RC_OP_HALT, 32'd0, h);
    check("halt_en", {31'd0, cpu_en}, 32'd0);
    check("halt_halted", {31'd0, halted}, 32'd1);
    exp_pc = exp_pc + 32'(4 * (h - a));
    repeat (3) @(negedge clk);
    check("run_pc", pc, exp_pc);
  endtask

  initial begin
    int unsigned a, h;
    int w;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;

    // Reset into HALTED
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_regaddr", {27'd0, regAddr}, 32'd0);
    check("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    repeat (10) @(negedge clk);
    check("rst_pc_idle", pc, 32'd0);

    do_step(5);
    check("step5_pc", pc, 32'h14);
    do_step(0);
    do_run(6, 1'b0);
    do_read(10, 4, 1'b0);
    do_run(3, 1'b1);

    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 3))
        0: do_step($urandom_range(0, 12));
        1: do_run($urandom_range(0, 8), 1'b0);
        2: do_read($urandom_range(0, 31), $urandom_range(0, 4), 1'b0);
        default: do_run($urandom_range(0, 5), 1'b1);
      endcase
    end

    // Unknown opcode in both accepting states
    send(3'b111, $urandom, a);
    check("nop_halted", {31'd0, halted}, 32'd1);
    check("nop_cpu_en", {31'd0, cpu_en}, 32'd0);
    repeat (3) @(negedge clk);
    check("nop_pc", pc, exp_pc);
    send(SM_RC_OP_RUN, 32'd0, a);
    send(3'b111, $urandom, h);
    check("nop_run_en", {31'd0, cpu_en}, 32'd1);
    send(SM_RC_OP_HALT, 32'd0, h);
    exp_pc = exp_pc + 32'(4 * (h - a));
    check("nop_run_pc", pc, exp_pc);

    // Reset in the middle of a long step
    send(SM_RC_OP_STEP, 32'd100, a);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", {31'd0, cpu_en}, 32'd0);
    check("mid_rst_halted", {31'd0, halted}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0;
    repeat (5) @(negedge clk);
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_en_after", {31'd0, cpu_en}, 32'd0);
    do_step(3);

    // Breakpoint at 0x10 from a known PC
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0;
    send(SM_RC_OP_SETBP, 32'h10, a);
    send(SM_RC_OP_RUN, 32'd0, a);
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
    w = 0;
    while (!halted && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("bp_stop_halted", {31'd0, halted}, 32'd1);
    check("bp_stop_pc", pc, 32'h10);
    check("bp_stop_flag", {31'd0, bp_hit}, 32'd1);
    send(SM_RC_OP_RUN, 32'd0, a);
    check("bp_resume_flag", {31'd0, bp_hit}, 32'd0);
    repeat (4) @(negedge clk);
    send(SM_RC_OP_HALT, 32'd0, h);
    exp_pc = 32'h10 + 32'(4 * (h - a));
    check("bp_resume_pc", pc, exp_pc);
    send(SM_RC_OP_CLRBP, 32'd0, a);
`else
    w = 0;
    repeat (10) @(negedge clk);
    check("nobp_flag", {31'd0, bp_hit}, 32'd0);
    check("nobp_en", {31'd0, cpu_en}, 32'd1);
    send(SM_RC_OP_HALT, 32'd0, h);
    exp_pc = 32'(4 * (h - a));
    check("nobp_pc", pc, exp_pc);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
